// File: rtl/ma_mem_ctrl_if.sv
// ============================================================================
// Module   : ma_mem_ctrl_if
// Brief    : Data-memory req/ack bus between the MA-stage controller and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ma_mem_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

`default_nettype wire

// File: rtl/ma_mem_ctrl.sv
// ============================================================================
// Module   : ma_mem_ctrl
// Brief    : MA-stage load/store controller; optional MA_MISALIGN_TRAP_EN traps
//            misaligned half/word accesses without a bus request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        M_valid,
  input  wire logic [31:0] M_alu_o,
  input  wire logic [31:0] M_wd,
  input  wire logic        M_we_dm,
  input  wire logic        M_re_dm,
  input  wire logic [2:0]  M_funct3,
  ma_mem_ctrl_if.master    bus,
  output logic [31:0]      M_dm_rd,
  output logic             M_stall,
  output logic             M_bus_err,
  output logic             M_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam bit         TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, rd_q;
  logic [3:0]  be_q;
  logic        we_q, bus_err_q, misalign_q;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;

  logic        mem_op, misalign, timeout;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte, cnt_inc;
  logic [15:0] ld_half;

  assign mem_op  = M_valid & (M_we_dm | M_re_dm);
  assign cnt_inc = cnt_q + 8'd1;
  assign timeout = TO_EN && (cnt_inc == TO_LIM);

`ifdef MA_MISALIGN_TRAP_EN
  assign misalign = ((M_funct3[1:0] == 2'b01) & M_alu_o[0]) |
                    (M_funct3[1] & (|M_alu_o[1:0]));
`else
  assign misalign = 1'b0;
`endif

  // funct3[1] selects word, so the reserved encodings 011/110/111 fall into it
  always_comb begin
    st_data = M_wd;
    st_be   = 4'b1111;
    case (M_funct3[1:0])
      2'b00: begin
        st_data = {4{M_wd[7:0]}};
        st_be   = 4'b0001 << M_alu_o[1:0];
      end
      2'b01: begin
        st_data = {2{M_wd[15:0]}};
        st_be   = M_alu_o[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ld_byte = bus.dm_rdata[{lo_q, 3'b000} +: 8];
  assign ld_half = bus.dm_rdata[{lo_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = bus.dm_rdata;
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_op) state_d = misalign ? S_DONE : S_BUS;
      S_BUS:   if (bus.dm_ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dm_req = 1'b0;
    M_stall    = 1'b0;
    case (state_q)
      S_IDLE:  M_stall = mem_op;
      S_BUS: begin
        bus.dm_req = 1'b1;
        M_stall    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      lo_q       <= '0;
      f3_q       <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_op && misalign) begin
            misalign_q <= 1'b1;
            if (!M_we_dm) rd_q <= '0;
          end else if (mem_op) begin
            addr_q  <= {M_alu_o[31:2], 2'b00};
            lo_q    <= M_alu_o[1:0];
            f3_q    <= M_funct3;
            we_q    <= M_we_dm;
            wdata_q <= st_data;
            be_q    <= st_be;
            cnt_q   <= '0;
          end
        end
        S_BUS: begin
          cnt_q <= cnt_inc;
          // An ack in the final allowed cycle still completes normally
          if (bus.dm_ack) begin
            if (!we_q) rd_q <= ld_data;
          end else if (timeout) begin
            rd_q      <= '0;
            bus_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dm_we    = we_q;
  assign bus.dm_addr  = addr_q;
  assign bus.dm_wdata = wdata_q;
  assign bus.dm_be    = be_q;
  assign M_dm_rd      = rd_q;
  assign M_bus_err    = bus_err_q;
  assign M_misalign   = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_ma_mem_ctrl.sv
// ============================================================================
// Module   : tb_ma_mem_ctrl
// Brief    : Directed self-checking bench for ma_mem_ctrl (TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ma_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid, M_we_dm, M_re_dm;
  logic [31:0] M_alu_o, M_wd;
  logic [2:0]  M_funct3;
  logic [31:0] M_dm_rd;
  logic        M_stall, M_bus_err, M_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_addr, cap_wdata, done_rd;
  logic [3:0]  cap_be;
  logic        cap_we, done_err, done_mis, done_ok;
  int          stall_cnt, req_cnt;

  ma_mem_ctrl_if bus ();

  ma_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .M_valid    (M_valid),
    .M_alu_o    (M_alu_o),
    .M_wd       (M_wd),
    .M_we_dm    (M_we_dm),
    .M_re_dm    (M_re_dm),
    .M_funct3   (M_funct3),
    .bus        (bus.master),
    .M_dm_rd    (M_dm_rd),
    .M_stall    (M_stall),
    .M_bus_err  (M_bus_err),
    .M_misalign (M_misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one MA-stage op; the bus acks in BUS cycle index ack_at (never if out of range)
  task automatic run_op(input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdata);
    M_valid = 1'b1; M_we_dm = we; M_re_dm = re; M_funct3 = f3;
    M_alu_o = addr; M_wd = wd;
    stall_cnt = 0; req_cnt = 0; done_ok = 1'b0;
    for (int c = 0; c < 20 && !done_ok; c++) begin
      @(negedge clk);
      if (bus.dm_req) begin
        cap_addr = bus.dm_addr; cap_wdata = bus.dm_wdata;
        cap_be = bus.dm_be; cap_we = bus.dm_we;
        if (req_cnt == ack_at) begin
          bus.dm_ack = 1'b1; bus.dm_rdata = rdata;
        end
        req_cnt++;
      end
      if (M_stall) stall_cnt++;
      else begin
        done_ok = 1'b1; done_rd = M_dm_rd;
        done_err = M_bus_err; done_mis = M_misalign;
      end
      @(posedge clk); #1;
      bus.dm_ack = 1'b0;
    end
    M_valid = 1'b0; M_we_dm = 1'b0; M_re_dm = 1'b0;
    if (!done_ok) check_eq("op_completes", 32'd0, 32'd1);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    run_op(1'b0, 1'b1, f3, addr, 32'h0, 0, rdata);
    check_eq({tag, "_rd"}, done_rd, exp);
    check_eq({tag, "_stall"}, stall_cnt, 2);
  endtask

  initial begin
    rst = 1'b1; M_valid = 1'b0; M_we_dm = 1'b0; M_re_dm = 1'b0;
    M_alu_o = '0; M_wd = '0; M_funct3 = '0;
    bus.dm_ack = 1'b0; bus.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req", bus.dm_req, 0);
    check_eq("rst_stall", M_stall, 0);
    check_eq("rst_rd", M_dm_rd, 0);
    check_eq("rst_be", bus.dm_be, 0);
    check_eq("rst_err", M_bus_err, 0);
    @(posedge clk); #1;

    run_load("lb",  3'b000, 32'h203, 32'h80FF1234, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h203, 32'h80FF1234, 32'h00000080);
    run_load("lh",  3'b001, 32'h202, 32'h80FF1234, 32'hFFFF80FF);
    run_load("lhu", 3'b101, 32'h202, 32'h80FF1234, 32'h000080FF);
    run_load("lw",  3'b010, 32'h200, 32'h80FF1234, 32'h80FF1234);
    check_eq("lw_addr", cap_addr, 32'h200);
    check_eq("lw_we", cap_we, 0);
    run_load("f3_011_word", 3'b011, 32'h200, 32'h12345678, 32'h12345678);

    run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h0);
    check_eq("sw_addr", cap_addr, 32'h104);
    check_eq("sw_be", cap_be, 4'b1111);
    check_eq("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check_eq("sw_we", cap_we, 1);
    check_eq("sw_stall", stall_cnt, 3);
    check_eq("sw_rd_kept", done_rd, 32'h12345678);

    // Both strobes high resolves to a store
    run_op(1'b1, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 0, 32'hFFFFFFFF);
    check_eq("sh_addr", cap_addr, 32'h100);
    check_eq("sh_be", cap_be, 4'b1100);
    check_eq("sh_wdata", cap_wdata, 32'hBEEFBEEF);
    check_eq("sh_we", cap_we, 1);
    check_eq("sh_rd_kept", done_rd, 32'h12345678);

    run_op(1'b1, 1'b0, 3'b000, 32'h11, 32'h000000A5, 0, 32'h0);
    check_eq("sb_addr", cap_addr, 32'h10);
    check_eq("sb_be", cap_be, 4'b0010);
    check_eq("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    check_eq("sb_rd_kept", done_rd, 32'h12345678);

    // Non-memory instruction: no stall, no request
    M_valid = 1'b1; M_alu_o = 32'h400;
    @(negedge clk);
    check_eq("nonmem_stall", M_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("nonmem_req", bus.dm_req, 0);
    check_eq("nonmem_rd", M_dm_rd, 32'h12345678);
    @(posedge clk); #1;
    M_valid = 1'b0;

    // Reset in the middle of a BUS cycle
    M_valid = 1'b1; M_re_dm = 1'b1; M_funct3 = 3'b010; M_alu_o = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_bus_req", bus.dm_req, 1);
    rst = 1'b1; M_valid = 1'b0; M_re_dm = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_rst_req", bus.dm_req, 0);
    check_eq("mid_rst_stall", M_stall, 0);
    check_eq("mid_rst_rd", M_dm_rd, 0);
    check_eq("mid_rst_addr", bus.dm_addr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; bus.dm_ack = 1'b1; bus.dm_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.dm_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_req", bus.dm_req, 0);
    check_eq("late_ack_stall", M_stall, 0);
    check_eq("late_ack_rd", M_dm_rd, 0);
    @(posedge clk); #1;

    run_load("lw_pre_to", 3'b010, 32'h200, 32'h0BADF00D, 32'h0BADF00D);

    run_op(1'b0, 1'b1, 3'b010, 32'h500, 32'h0, 99, 32'hFFFFFFFF);
    check_eq("to_req_cycles", req_cnt, 4);
    check_eq("to_stall", stall_cnt, 5);
    check_eq("to_err", done_err, 1);
    check_eq("to_rd", done_rd, 0);
    @(negedge clk);
    check_eq("to_err_pulse", M_bus_err, 0);
    @(posedge clk); #1;

`ifdef MA_MISALIGN_TRAP_EN
    run_load("lw_pre_mis", 3'b010, 32'h200, 32'h13579BDF, 32'h13579BDF);
    run_op(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D);
    check_eq("mis_req", req_cnt, 0);
    check_eq("mis_flag", done_mis, 1);
    check_eq("mis_rd", done_rd, 0);
    check_eq("mis_stall", stall_cnt, 1);
    @(negedge clk);
    check_eq("mis_pulse", M_misalign, 0);
    @(posedge clk); #1;
`else
    run_op(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D);
    check_eq("unal_addr", cap_addr, 32'h100);
    check_eq("unal_rd", done_rd, 32'hCAFEF00D);
    check_eq("unal_flag", done_mis, 0);
    check_eq("unal_stall", stall_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
